alu_issue: RTL
==============

Name: alu_issue

Overview:
- Initiator side of the 16-bit ALU interface: accepts one register-to-register operation per handshake, reads operands from an internal register file, drives the combinational ALU, captures result/NZCV, and writes back.
- Sits between the instruction decode stage and the ALU; owns the architectural register file and the flags register.
- Fixed 3-cycle operation, with no overlap between operations.

Parameters:
- REG_AW, 3, register-address width; register count is 2**REG_AW. r0 reads as zero.
- DATA_W, 16, datapath width. Fixed at 16 to match the ALU; other values are unsupported.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  high only in IDLE.
- in_op  in  5  ALU opcode, 5'b00000..5'b01111 (ADD..CMP encoding).
- in_rd  in  REG_AW  destination register.
- in_ra  in  REG_AW  source register A.
- in_rb  in  REG_AW  source register B.
- alu_op  out  5  opcode to ALU.
- alu_a  out  DATA_W  operand A to ALU.
- alu_b  out  DATA_W  operand B to ALU.
- alu_c_in  out  1  carry-in to ALU; equals flags[1].
- alu_result  in  DATA_W  ALU result.
- alu_nzcv  in  4  ALU flags {N,Z,C,V}.
- wb_valid  out  1  one-cycle pulse when a register write commits.
- wb_rd  out  REG_AW  written register.
- wb_data  out  DATA_W  written value.
- flags  out  4  architectural NZCV.
- err  out  1  one-cycle pulse on illegal opcode or divide-by-zero.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational register-file read of dbg_addr.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state = IDLE, in_ready = 1
  - all registers = 0, flags = 0
  - wb_valid = 0, err = 0, wb_rd = 0, wb_data = 0
  - alu_op/alu_a/alu_b = 0
  
  Reset mid-operation aborts it: no writeback occurs and flags are not updated.
- FSM: IDLE -> EXEC -> WB -> IDLE.
  - IDLE: in_ready = 1. When in_valid & in_ready at edge N, latch op, rd, R[ra], R[rb] (r0 = 0), then go to EXEC.
  - EXEC (cycle N+1): alu_* outputs are driven from the latched values. At the edge ending EXEC, capture alu_result and alu_nzcv, then go to WB.
  - WB (cycle N+2): commit the writeback and/or flags update, pulse wb_valid/err as applicable, return to IDLE. in_ready is high again in N+3.
- alu_* outputs hold their last values outside EXEC.
- Commit rules:
  - Normal op: R[rd] = result; flags = alu_nzcv; wb_valid = 1.
  - CMP (5'b01111): flags only; wb_valid = 0.
  - rd = 0: flags still update; register write is suppressed; wb_valid = 0.
  - DIV with operand B = 0: ALU output is ignored. R[rd] = 16'hFFFF, flags = 4'b1001 (N, V), err = 1, wb_valid = 1 (if rd != 0).
  - Opcode > 5'b01111: no write, flags unchanged, err = 1.
- Sources are read at accept time, so ra == rd of the previous op sees the committed value; no hazards are possible.
- in_op/in_r* are ignored whenever in_ready = 0.

Optional Feature:
- Macro: ALU_ISSUE_FLAGS_PASS_EN.
- Defined: logic ops (AND..XNOR) update only N and Z; C and V are preserved from the prior flags.
- Undefined: all legal ops load all four flags from alu_nzcv.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_OP_* 5-bit opcode constants
  - ALU_OP_LAST = 5'b01111
  - NZCV bit indices (N = 3, Z = 2, C = 1, V = 0)
  - DIV0_RESULT = 16'hFFFF
- One natural sub-module: alu_regfile. It has one synchronous write port, two combinational read ports plus the debug port, and r0 forced to zero.
- The FSM and commit logic stay in alu_issue.

Test Plan:
- Reset, then dbg_addr sweep over 0..7 -> all dbg_data = 0; flags = 0; in_ready = 1.
- Preload r1 = 5 and r2 = 3 using a bench ALU model; issue ADD rd=3, ra=1, rb=2 -> wb_valid at N+2 with wb_rd = 3, wb_data = 8; flags = 4'b0000; in_ready high at N+3.
- CMP ra=1 (5), rb=2 (5) -> wb_valid never asserts; flags Z = 1; registers unchanged.
- DIV rd=4, ra=1 (7), rb=0 -> R4 = 16'hFFFF; err pulses at N+2; flags = 4'b1001.
- Opcode 5'b10101 -> err pulse; no wb_valid; flags unchanged. Separately, ADD with rd=0 -> r0 still reads 0.
- Accept an op, then drop rst_n during EXEC -> no wb_valid; all registers 0; in_ready = 1 the cycle after reset is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode map, flag bit positions and divide-by-zero result value.
package alu_pkg;

  localparam logic [4:0] ALU_OP_ADD  = 5'h00;
  localparam logic [4:0] ALU_OP_ADC  = 5'h01;
  localparam logic [4:0] ALU_OP_SUB  = 5'h02;
  localparam logic [4:0] ALU_OP_SBC  = 5'h03;
  localparam logic [4:0] ALU_OP_AND  = 5'h04;
  localparam logic [4:0] ALU_OP_OR   = 5'h05;
  localparam logic [4:0] ALU_OP_XOR  = 5'h06;
  localparam logic [4:0] ALU_OP_NAND = 5'h07;
  localparam logic [4:0] ALU_OP_NOR  = 5'h08;
  localparam logic [4:0] ALU_OP_XNOR = 5'h09;
  localparam logic [4:0] ALU_OP_SHL  = 5'h0a;
  localparam logic [4:0] ALU_OP_SHR  = 5'h0b;
  localparam logic [4:0] ALU_OP_SAR  = 5'h0c;
  localparam logic [4:0] ALU_OP_MUL  = 5'h0d;
  localparam logic [4:0] ALU_OP_DIV  = 5'h0e;
  localparam logic [4:0] ALU_OP_CMP  = 5'h0f;
  localparam logic [4:0] ALU_OP_LAST = 5'h0f;

  // Bit positions inside a {N,Z,C,V} flags vector.
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

  // Bitwise ops: their C/V outputs carry no arithmetic meaning.
  function automatic logic is_logic_op(input logic [4:0] op);
    return (op >= ALU_OP_AND) && (op <= ALU_OP_XNOR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: one synchronous write port, two combinational
// read ports and a combinational debug read port. r0 always reads as zero.
module alu_regfile #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Synchronous clear on reset, otherwise write any register except r0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one register-to-register op per handshake, drives
// the external combinational ALU for one cycle, then commits result and flags.
// Fixed IDLE -> EXEC -> WB sequence, no overlap between operations.
// Optional: ALU_ISSUE_FLAGS_PASS_EN makes AND..XNOR update only N and Z,
// keeping C and V from the previous flags.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]        r_state;
  logic [4:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_flags;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err;

  logic              w_accept;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic              w_we;
  logic              w_flags_we;
  logic              w_err;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_nzcv;

  assign w_accept = in_valid && (r_state == S_IDLE);

  alu_regfile #(
    .REG_AW (REG_AW),
    .DATA_W (DATA_W)
  ) u_regfile (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (w_wdata),
    .i_raddr_a  (in_ra),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (in_rb),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Sequencer: one accepted op walks IDLE -> EXEC -> WB -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_EXEC;
        S_EXEC:  r_state <= S_WB;
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture at accept; these registers also drive the ALU and hold
  // their values until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op <= '0;
      r_rd <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= in_op;
      r_rd <= in_rd;
      r_a  <= w_rdata_a;
      r_b  <= w_rdata_b;
    end
  end

`ifdef ALU_ISSUE_FLAGS_PASS_EN
  logic w_logic_op;
  assign w_logic_op = is_logic_op(r_op);
`endif

  // Commit decision, evaluated during EXEC from the live ALU outputs; the
  // register file and flags are written on the edge that ends EXEC.
  always_comb begin
    w_we       = 1'b0;
    w_flags_we = 1'b0;
    w_err      = 1'b0;
    w_wdata    = alu_result;
    w_nzcv     = alu_nzcv;
    if (r_state == S_EXEC) begin
      if (r_op > ALU_OP_LAST) begin
        w_err = 1'b1;
      end else if ((r_op == ALU_OP_DIV) && (r_b == '0)) begin
        w_wdata    = DIV0_RESULT;
        w_nzcv     = 4'b1001;
        w_err      = 1'b1;
        w_flags_we = 1'b1;
        w_we       = (r_rd != '0);
      end else begin
        w_flags_we = 1'b1;
        w_we       = (r_op != ALU_OP_CMP) && (r_rd != '0);
`ifdef ALU_ISSUE_FLAGS_PASS_EN
        if (w_logic_op) begin
          w_nzcv[NZCV_C] = r_flags[NZCV_C];
          w_nzcv[NZCV_V] = r_flags[NZCV_V];
        end
`endif
      end
    end
  end

  // Flags register and the one-cycle writeback/error pulses seen during WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= w_we;
      r_err      <= w_err;
      if (w_flags_we) r_flags <= w_nzcv;
      if (w_we) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_wdata;
      end
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign alu_op   = r_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_c_in = r_flags[NZCV_C];
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign flags    = r_flags;
  assign err      = r_err;

endmodule
